// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks {dest, WB_en, MEM_R_en} for the EXE, MEM and WB
// stages, feeds MEM/WB destinations to the forwarding selector, and requests
// an IF/ID stall when forwarding cannot resolve a source-operand dependency.
// Also keeps a saturating count of stalled cycles.
//
// Flow control: there is no valid/ready pair on this block. ID_valid marks a
// real instruction in ID; hazard_detected is the inverse of "ready" for that
// instruction. When hazard_detected=1 the ID instruction is not accepted and
// a bubble enters EXE instead. The upstream stages must hold ID stable until
// hazard_detected drops. freeze stalls the whole tracked pipeline and
// overrides acceptance.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_forwarding,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  ID_valid,
  input  logic [REG_ADDR_W-1:0] ID_src1,
  input  logic [REG_ADDR_W-1:0] ID_src2,
  input  logic                  ID_two_src,
  input  logic [REG_ADDR_W-1:0] ID_dest,
  input  logic                  ID_WB_en,
  input  logic                  ID_MEM_R_en,
  output logic [REG_ADDR_W-1:0] EXE_dest,
  output logic                  EXE_WB_en,
  output logic                  EXE_MEM_R_en,
  output logic [REG_ADDR_W-1:0] MEM_dest,
  output logic                  MEM_WB_en,
  output logic [REG_ADDR_W-1:0] WB_dest,
  output logic                  WB_WB_en,
  output logic                  hazard_detected,
  output logic [CNT_W-1:0]      stall_cycles
);

  // One tracked pipeline entry. An all-zero entry is a bubble.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic                  wb_en;
    logic                  mem_r_en;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  // Stage registers and counter
  stage_t           r_exe;
  stage_t           r_mem;
  stage_t           r_wb;
  logic [CNT_W-1:0] r_stall_cycles;

  // Combinational terms
  stage_t w_id_entry;
  logic   w_m1_exe;
  logic   w_m2_exe;
  logic   w_m1_mem;
  logic   w_m2_mem;
  logic   w_dep_exe;
  logic   w_dep_mem;
  logic   w_load_use;
  logic   w_inflight_dep;
  logic   w_raw_hazard;
  logic   w_id_live;
  logic   w_hazard;
  logic   w_insert_bubble;
  logic   w_count_en;
  logic   w_cnt_sat;

  // Entry that EXE would take if the ID instruction is accepted.
  always_comb begin
    w_id_entry          = BUBBLE;
    w_id_entry.dest     = ID_dest;
    w_id_entry.wb_en    = ID_WB_en;
    w_id_entry.mem_r_en = ID_MEM_R_en;
  end

  // Source-operand matches against the EXE and MEM producers. WB is never
  // compared: the register file writes in the first half-cycle and reads in
  // the second, so a WB producer is always visible to ID.
  always_comb begin
    w_m1_exe  = (ID_src1 == r_exe.dest) & r_exe.wb_en;
    w_m2_exe  = (ID_src2 == r_exe.dest) & r_exe.wb_en & ID_two_src;
    w_m1_mem  = (ID_src1 == r_mem.dest) & r_mem.wb_en;
    w_m2_mem  = (ID_src2 == r_mem.dest) & r_mem.wb_en & ID_two_src;
    w_dep_exe = w_m1_exe | w_m2_exe;
    w_dep_mem = w_m1_mem | w_m2_mem;
  end

  // Hazard selection. With forwarding, only a load still in EXE is
  // unresolvable (its data appears at the end of MEM). Without forwarding,
  // any producer in EXE or MEM must drain to WB first. A killed or empty ID
  // slot never stalls.
  always_comb begin
    w_load_use     = w_dep_exe & r_exe.mem_r_en;
    w_inflight_dep = w_dep_exe | w_dep_mem;
    w_raw_hazard   = enable_forwarding ? w_load_use : w_inflight_dep;
    w_id_live      = ID_valid & ~flush;
    w_hazard       = w_raw_hazard & w_id_live;
  end

  // Bubble selection and counter enable. While frozen nothing advances and
  // the stall is not counted; it is counted on the edge where freeze drops
  // if the hazard is still present then.
  always_comb begin
    w_insert_bubble = flush | w_hazard | ~ID_valid;
    w_count_en      = w_hazard & ~freeze;
    w_cnt_sat       = &r_stall_cycles;
  end

  // Tracking pipeline: shifts one stage per edge unless frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exe <= BUBBLE;
      r_mem <= BUBBLE;
      r_wb  <= BUBBLE;
    end else if (!freeze) begin
      r_wb  <= r_mem;
      r_mem <= r_exe;
      r_exe <= w_insert_bubble ? BUBBLE : w_id_entry;
    end
  end

  // Saturating stall-cycle counter; holds at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_count_en && !w_cnt_sat) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  // Output mapping
  always_comb begin
    EXE_dest        = r_exe.dest;
    EXE_WB_en       = r_exe.wb_en;
    EXE_MEM_R_en    = r_exe.mem_r_en;
    MEM_dest        = r_mem.dest;
    MEM_WB_en       = r_mem.wb_en;
    WB_dest         = r_wb.dest;
    WB_WB_en        = r_wb.wb_en;
    hazard_detected = w_hazard;
    stall_cycles    = r_stall_cycles;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic, checked
// against a stage-list reference model kept in the bench.
module tb_hazard_scoreboard;

  localparam int RW = 4;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, enable_forwarding, freeze, flush, ID_valid;
  logic [RW-1:0] ID_src1, ID_src2, ID_dest;
  logic          ID_two_src, ID_WB_en, ID_MEM_R_en;

  logic [RW-1:0] EXE_dest, MEM_dest, WB_dest;
  logic          EXE_WB_en, EXE_MEM_R_en, MEM_WB_en, WB_WB_en, hazard_detected;
  logic [15:0]   stall_cycles;

  logic [RW-1:0] s_EXE_dest, s_MEM_dest, s_WB_dest;
  logic          s_EXE_WB_en, s_EXE_MEM_R_en, s_MEM_WB_en, s_WB_WB_en, s_hazard;
  logic [1:0]    s_stall_cycles;

  hazard_scoreboard #(.REG_ADDR_W(RW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable_forwarding(enable_forwarding),
    .freeze(freeze), .flush(flush), .ID_valid(ID_valid),
    .ID_src1(ID_src1), .ID_src2(ID_src2), .ID_two_src(ID_two_src),
    .ID_dest(ID_dest), .ID_WB_en(ID_WB_en), .ID_MEM_R_en(ID_MEM_R_en),
    .EXE_dest(EXE_dest), .EXE_WB_en(EXE_WB_en), .EXE_MEM_R_en(EXE_MEM_R_en),
    .MEM_dest(MEM_dest), .MEM_WB_en(MEM_WB_en),
    .WB_dest(WB_dest), .WB_WB_en(WB_WB_en),
    .hazard_detected(hazard_detected), .stall_cycles(stall_cycles)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  hazard_scoreboard #(.REG_ADDR_W(RW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .enable_forwarding(enable_forwarding),
    .freeze(freeze), .flush(flush), .ID_valid(ID_valid),
    .ID_src1(ID_src1), .ID_src2(ID_src2), .ID_two_src(ID_two_src),
    .ID_dest(ID_dest), .ID_WB_en(ID_WB_en), .ID_MEM_R_en(ID_MEM_R_en),
    .EXE_dest(s_EXE_dest), .EXE_WB_en(s_EXE_WB_en), .EXE_MEM_R_en(s_EXE_MEM_R_en),
    .MEM_dest(s_MEM_dest), .MEM_WB_en(s_MEM_WB_en),
    .WB_dest(s_WB_dest), .WB_WB_en(s_WB_WB_en),
    .hazard_detected(s_hazard), .stall_cycles(s_stall_cycles)
  );

  // Scoreboard counters
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: list of in-flight instructions, index 0 = EXE.
  typedef struct {
    int dest;
    bit wb;
    bit ld;
  } ent_t;

  ent_t pipe [3];
  int   exp_cnt;

  function automatic bit reads_reg(int r);
    return (int'(ID_src1) == r) || (ID_two_src && int'(ID_src2) == r);
  endfunction

  // An instruction in ID must stall if a source is produced by something
  // whose value is not yet obtainable: a load in EXE with forwarding, or
  // anything in EXE/MEM without forwarding.
  function automatic bit model_hazard();
    if (!ID_valid || flush) return 1'b0;
    for (int s = 0; s < 2; s++) begin
      if (pipe[s].wb && reads_reg(pipe[s].dest)) begin
        if (!enable_forwarding) return 1'b1;
        if (s == 0 && pipe[s].ld) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int sat(int v, int max);
    return (v > max) ? max : v;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 3; s++) pipe[s] = '{0, 1'b0, 1'b0};
    exp_cnt = 0;
  endtask

  task automatic model_edge();
    bit hz;
    ent_t nxt;
    hz = model_hazard();
    if (rst) begin
      model_clear();
    end else if (!freeze) begin
      if (hz) exp_cnt++;
      if (flush || hz || !ID_valid) nxt = '{0, 1'b0, 1'b0};
      else nxt = '{int'(ID_dest), ID_WB_en, ID_MEM_R_en};
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nxt;
    end
  endtask

  task automatic model_check();
    bit hz;
    hz = model_hazard();
    check("exe_dest",  {28'd0, EXE_dest},   pipe[0].dest);
    check("exe_wb",    {31'd0, EXE_WB_en},  {31'd0, pipe[0].wb});
    check("exe_ld",    {31'd0, EXE_MEM_R_en}, {31'd0, pipe[0].ld});
    check("mem_dest",  {28'd0, MEM_dest},   pipe[1].dest);
    check("mem_wb",    {31'd0, MEM_WB_en},  {31'd0, pipe[1].wb});
    check("wb_dest",   {28'd0, WB_dest},    pipe[2].dest);
    check("wb_wb",     {31'd0, WB_WB_en},   {31'd0, pipe[2].wb});
    check("hazard",    {31'd0, hazard_detected}, {31'd0, hz});
    check("hazard_s",  {31'd0, s_hazard},   {31'd0, hz});
    check("cnt16",     {16'd0, stall_cycles}, sat(exp_cnt, 65535));
    check("cnt2",      {30'd0, s_stall_cycles}, sat(exp_cnt, 3));
  endtask

  // Driver tasks
  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_id(input bit v, input int s1, input int s2, input bit two,
                        input int d, input bit wb, input bit ld);
    ID_valid    = v;
    ID_src1     = RW'(s1);
    ID_src2     = RW'(s2);
    ID_two_src  = two;
    ID_dest     = RW'(d);
    ID_WB_en    = wb;
    ID_MEM_R_en = ld;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int base;

  initial begin
    rst = 1'b1; enable_forwarding = 1'b1; freeze = 1'b0; flush = 1'b0;
    set_id(1'($urandom), $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom),
           $urandom_range(0, 15), 1'($urandom), 1'($urandom));
    model_clear();
    @(posedge clk);
    #1;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      set_id(1'($urandom), $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom),
             $urandom_range(0, 15), 1'($urandom), 1'($urandom));
      tick();
    end
    check("rst_exe_wb", {31'd0, EXE_WB_en}, 32'd0);
    check("rst_cnt",    {16'd0, stall_cycles}, 32'd0);
    check("rst_haz",    {31'd0, hazard_detected}, 32'd0);
    rst = 1'b0;
    idle();
    tick();

    // Load-use with forwarding: one stall cycle
    enable_forwarding = 1'b1;
    set_id(1'b1, 0, 0, 1'b0, 3, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 3, 0, 1'b0, 7, 1'b1, 1'b0);
    check("lu_haz_on", {31'd0, hazard_detected}, 32'd1);
    tick();
    check("lu_bubble",   {31'd0, EXE_WB_en}, 32'd0);
    check("lu_mem_dest", {28'd0, MEM_dest}, 32'd3);
    check("lu_mem_wb",   {31'd0, MEM_WB_en}, 32'd1);
    check("lu_haz_off",  {31'd0, hazard_detected}, 32'd0);
    tick();
    check("lu_cnt", {16'd0, stall_cycles}, 32'd1);
    idle();
    tick();
    do_reset();

    // ALU dependency with forwarding: no stall
    set_id(1'b1, 0, 0, 1'b0, 5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 1, 5, 1'b1, 6, 1'b1, 1'b0);
    check("alu_fwd_haz", {31'd0, hazard_detected}, 32'd0);
    tick();
    check("alu_fwd_mem", {28'd0, MEM_dest}, 32'd5);
    idle();
    tick();
    tick();

    // ALU dependency without forwarding: two stall cycles, three times over
    // so the 2-bit counter saturates at 3 while the 16-bit one reaches 6.
    enable_forwarding = 1'b0;
    do_reset();
    for (int rep = 0; rep < 3; rep++) begin
      set_id(1'b1, 0, 0, 1'b0, 5, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 1, 5, 1'b1, 6, 1'b1, 1'b0);
      check("nofwd_haz1", {31'd0, hazard_detected}, 32'd1);
      tick();
      check("nofwd_haz2", {31'd0, hazard_detected}, 32'd1);
      tick();
      check("nofwd_haz3", {31'd0, hazard_detected}, 32'd0);
      tick();
      idle();
      tick(); tick(); tick();
    end
    check("nofwd_cnt", {16'd0, stall_cycles}, 32'd6);
    check("sat_cnt",   {30'd0, s_stall_cycles}, 32'd3);
    // Single-source read must ignore ID_src2
    set_id(1'b1, 0, 0, 1'b0, 5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 9, 5, 1'b0, 6, 1'b1, 1'b0);
    check("nofwd_one_src", {31'd0, hazard_detected}, 32'd0);
    tick();
    idle();
    tick(); tick();

    // Freeze with a load in EXE and a dependent in ID
    enable_forwarding = 1'b1;
    do_reset();
    set_id(1'b1, 0, 0, 1'b0, 4, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 2, 4, 1'b1, 8, 1'b1, 1'b0);
    freeze = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_exe_dest", {28'd0, EXE_dest}, 32'd4);
      check("frz_haz",      {31'd0, hazard_detected}, 32'd1);
      check("frz_cnt",      {16'd0, stall_cycles}, 32'd0);
    end
    freeze = 1'b0;
    #1;
    tick();
    check("frz_bubble", {31'd0, EXE_WB_en}, 32'd0);
    check("frz_cnt1",   {16'd0, stall_cycles}, 32'd1);
    tick();
    check("frz_flow", {28'd0, EXE_dest}, 32'd8);
    idle();
    tick(); tick(); tick();

    // Flush together with a load-use match
    set_id(1'b1, 0, 0, 1'b0, 2, 1'b1, 1'b1);
    tick();
    base = int'(stall_cycles);
    set_id(1'b1, 2, 0, 1'b0, 9, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    check("flush_haz", {31'd0, hazard_detected}, 32'd0);
    tick();
    flush = 1'b0;
    check("flush_bubble", {31'd0, EXE_WB_en}, 32'd0);
    check("flush_cnt",    {16'd0, stall_cycles}, base);
    idle();
    tick(); tick(); tick();

    // Randomized traffic; small register range to make matches frequent
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) enable_forwarding = 1'($urandom);
      rst    = ($urandom_range(0, 199) == 0);
      freeze = ($urandom_range(0, 9) == 0);
      flush  = ($urandom_range(0, 9) == 0);
      set_id(($urandom_range(0, 9) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom), $urandom_range(0, 3), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 2) == 0));
      tick();
    end
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
